// File: rtl/downcounter_timer.sv
// Loadable down-counter with one-shot / auto-reload modes and a 1-cycle terminal-count pulse.
// Optional sticky done flag with clear input when DOWNCTR_STICKY_DONE_EN is defined.
module downcounter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             auto_reload,
`ifdef DOWNCTR_STICKY_DONE_EN
    input  logic             done_clr,
    output logic             done,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
`ifdef DOWNCTR_STICKY_DONE_EN
    logic             done_q, done_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
`ifdef DOWNCTR_STICKY_DONE_EN
            done_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
`ifdef DOWNCTR_STICKY_DONE_EN
            done_q   <= done_d;
`endif
        end
    end

    // Priority: load > stop > start > enabled count
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = IDLE;
        end else if (stop && state_q == RUN) begin
            state_d = IDLE;
        end else if (start && state_q == IDLE) begin
            if (count_q != '0) begin
                state_d = RUN;
            end
        end else if (state_q == RUN && en) begin
            if (count_q == ONE) begin
                tc_d = 1'b1;
                if (auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end else if (count_q != '0) begin
                count_d = count_q - ONE;
            end
        end
`ifdef DOWNCTR_STICKY_DONE_EN
        done_d = done_q;
        if (tc_d) begin
            done_d = 1'b1;
        end else if (done_clr || load) begin
            done_d = 1'b0;
        end
`endif
    end

    always_comb begin
        count = count_q;
        tc    = tc_q;
        busy  = (state_q == RUN);
`ifdef DOWNCTR_STICKY_DONE_EN
        done  = done_q;
`endif
    end

endmodule

// File: tb/tb_downcounter_timer.sv
// Bench for downcounter_timer: directed scenarios then random traffic vs. a cycle model.
// Also exercises the sticky done flag when DOWNCTR_STICKY_DONE_EN is defined.
module tb_downcounter_timer;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       stop;
    logic       en;
    logic       auto_reload;
    logic       done_clr;
    logic       done;
    logic [3:0] count;
    logic       tc;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [3:0] m_count;
    logic [3:0] m_reload;
    logic       m_run;
    logic       m_tc;
    logic       m_done;

    downcounter_timer #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .stop        (stop),
        .en          (en),
        .auto_reload (auto_reload),
`ifdef DOWNCTR_STICKY_DONE_EN
        .done_clr    (done_clr),
        .done        (done),
`endif
        .count       (count),
        .tc          (tc),
        .busy        (busy)
    );

`ifndef DOWNCTR_STICKY_DONE_EN
    assign done = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: one clock of the timer's documented rules, applied to the
    // input values that the DUT will sample at the coming edge.
    task automatic model_step();
        logic fire;
        fire = 1'b0;
        if (!rst_n) begin
            m_count = 0; m_reload = 0; m_run = 0; m_done = 0;
        end else begin
            if (load) begin
                m_count = load_val; m_reload = load_val; m_run = 0;
            end else if (stop && m_run) begin
                m_run = 0;
            end else if (start && !m_run) begin
                m_run = (m_count != 0);
            end else if (m_run && en) begin
                if (m_count == 1) begin
                    fire = 1'b1;
                    if (auto_reload) m_count = m_reload;
                    else begin m_count = 0; m_run = 0; end
                end else begin
                    m_count = m_count - 4'd1;
                end
            end
            if (fire) m_done = 1;
            else if (done_clr || load) m_done = 0;
        end
        m_tc = fire;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("count", 32'(count), 32'(m_count));
        chk("tc", 32'(tc), 32'(m_tc));
        chk("busy", 32'(busy), 32'(m_run));
`ifdef DOWNCTR_STICKY_DONE_EN
        chk("done", 32'(done), 32'(m_done));
`endif
    endtask

    task automatic idle_inputs();
        rst_n = 1; load = 0; start = 0; stop = 0;
        en = 1; auto_reload = 0; done_clr = 0;
    endtask

    initial begin
        int tcs;
        logic [3:0] seq3 [10];
        seq3 = '{4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
        idle_inputs();
        load_val = 4'd9;

        // 1: reset dominates load/start
        rst_n = 0; load = 1; start = 1;
        repeat (2) begin
            cyc();
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        idle_inputs();

        // 2: one-shot from 5
        load = 1; load_val = 4'd5; cyc();
        load = 0; start = 1; cyc();
        start = 0;
        repeat (5) cyc();
        chk("oneshot_end", 32'(count), 32'd0);
        chk("oneshot_tc", 32'(tc), 32'd1);
        chk("oneshot_busy", 32'(busy), 32'd0);
        cyc();
        chk("oneshot_tc_gone", 32'(tc), 32'd0);

        // 3: auto-reload period 3
        load = 1; load_val = 4'd3; auto_reload = 1; cyc();
        load = 0; start = 1; cyc();
        start = 0; tcs = 0;
        chk("ar_seq0", 32'(count), 32'(seq3[0]));
        for (int i = 1; i < 10; i++) begin
            cyc();
            chk("ar_seq", 32'(count), 32'(seq3[i]));
            if (tc) tcs++;
        end
        chk("ar_tcs", 32'(tcs), 32'd3);
        chk("ar_busy", 32'(busy), 32'd1);

        // 4: gated enable, stop at 8, resume
        load = 1; load_val = 4'd15; auto_reload = 0; cyc();
        load = 0; start = 1; cyc();
        start = 0;
        for (int i = 0; i < 40 && count != 4'd8; i++) begin
            en = ~en; cyc();
        end
        chk("reach8", 32'(count), 32'd8);
        stop = 1; en = 1; cyc();
        stop = 0;
        chk("stop_busy", 32'(busy), 32'd0);
        cyc();
        chk("stop_hold", 32'(count), 32'd8);
        start = 1; cyc();
        start = 0; cyc();
        chk("resume", 32'(count), 32'd7);

        // 5: load+start mid-run aborts, start dropped
        load = 1; load_val = 4'd9; cyc();
        load = 0; start = 1; cyc();
        start = 0;
        for (int i = 0; i < 20 && count != 4'd6; i++) cyc();
        load = 1; load_val = 4'd2; start = 1; cyc();
        load = 0; start = 0;
        chk("abort_count", 32'(count), 32'd2);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_tc", 32'(tc), 32'd0);
        start = 1; cyc();
        start = 0; cyc(); cyc();
        chk("abort_tc2", 32'(tc), 32'd1);

        // load 0 then start is ignored
        load = 1; load_val = 4'd0; cyc();
        load = 0; start = 1; cyc();
        start = 0;
        chk("zero_busy", 32'(busy), 32'd0);

`ifdef DOWNCTR_STICKY_DONE_EN
        // 6: sticky done, clear in tc cycle loses
        load = 1; load_val = 4'd2; cyc();
        load = 0; start = 1; cyc();
        start = 0; cyc();
        done_clr = 1; cyc();
        chk("done_set", 32'(done), 32'd1);
        done_clr = 0; cyc(); cyc();
        chk("done_sticky", 32'(done), 32'd1);
        done_clr = 1; cyc();
        done_clr = 0;
        chk("done_clr", 32'(done), 32'd0);
`endif

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst_n       = ($urandom_range(59, 0) != 0);
            load        = ($urandom_range(9, 0) == 0);
            load_val    = 4'($urandom_range(15, 0));
            start       = ($urandom_range(3, 0) == 0);
            stop        = ($urandom_range(11, 0) == 0);
            en          = ($urandom_range(3, 0) != 0);
            auto_reload = 1'($urandom_range(1, 0));
            done_clr    = ($urandom_range(4, 0) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
